// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: multiplexed common-anode hex display driver with blanking gaps and double-buffered value
// Ports: clk, rst (async, active-high); value_load strobe captures value/dots/digit_en into the pending buffer;
//   lz_suppress level blanks leading zeros; anodes/segments/dp are active-low registered pin drives;
//   frame_done pulses one cycle after the last digit's SHOW phase ends.
module seven_segment (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end
endmodule

module seven_segment_scanner #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 5000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  value_load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dots,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic                  lz_suppress,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic                  frame_done
);
  localparam int IW   = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int TMAX = CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  typedef enum logic {BLANK, SHOW} state_t;
  state_t              state;
  logic [IW-1:0]       idx;
  logic [TW-1:0]       timer;
  logic [4*DIGITS-1:0] act_val, pend_val;
  logic [DIGITS-1:0]   act_dots, act_en, pend_dots, pend_en;
  logic                pend;
  logic [3:0]          nib;
  logic [6:0]          seg_d;
  logic                lit, last_show, boundary;
  seven_segment u_dec (.hex(nib), .seg(seg_d));
  // Suppression looks at the current digit and everything to its left; digit 0 is never suppressed.
  always_comb begin
    nib       = act_val[idx*4 +: 4];
    lit       = act_en[idx] & ~(lz_suppress & (idx != '0) & ((act_val >> (idx*4)) == '0));
    last_show = (state == SHOW) && (timer == TW'(CLK_DIV - 1));
    boundary  = last_show && (idx == IW'(DIGITS - 1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= '0;
      timer      <= '0;
      act_val    <= '0;
      act_dots   <= '0;
      act_en     <= '0;
      pend_val   <= '0;
      pend_dots  <= '0;
      pend_en    <= '0;
      pend       <= 1'b0;
      anodes     <= '1;
      segments   <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      // A load landing on the boundary bypasses the pending buffer and goes live immediately.
      if (boundary) begin
        act_val  <= value_load ? value : pend ? pend_val : act_val;
        act_dots <= value_load ? dots : pend ? pend_dots : act_dots;
        act_en   <= value_load ? digit_en : pend ? pend_en : act_en;
        pend     <= 1'b0;
      end else if (value_load) begin
        pend_val  <= value;
        pend_dots <= dots;
        pend_en   <= digit_en;
        pend      <= 1'b1;
      end
      if (state == BLANK) begin
        if (timer == TW'(BLANK_CYCLES - 1)) begin
          state    <= SHOW;
          timer    <= '0;
          anodes   <= lit ? ~(DIGITS'(1) << idx) : '1;
          segments <= seg_d;
          dp       <= lit ? ~act_dots[idx] : 1'b1;
        end else begin
          timer <= timer + 1'b1;
        end
      end else if (last_show) begin
        state    <= BLANK;
        timer    <= '0;
        idx      <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        anodes   <= '1;
        segments <= 7'h7F;
        dp       <= 1'b1;
      end else begin
        timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: randomized and directed checks of the scanner against a slot-arithmetic reference model
module tb_seven_segment_scanner;
  localparam int D = 4, CD = 4, BC = 2, SLOT = BC + CD, FRAME = D * SLOT;
  logic clk = 0, rst = 1, value_load = 0, lz_suppress = 0;
  logic [15:0] value = '0;
  logic [3:0]  dots = '0, digit_en = '0;
  logic [3:0]  anodes;
  logic [6:0]  segments;
  logic        dp, frame_done;
  int checks = 0, failures = 0;
  seven_segment_scanner #(.DIGITS(D), .CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .value_load(value_load), .value(value), .dots(dots),
    .digit_en(digit_en), .lz_suppress(lz_suppress), .anodes(anodes),
    .segments(segments), .dp(dp), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  // Reference model: cycle n after reset sits in slot n/SLOT, phase n%SLOT; frames switch at multiples of FRAME.
  logic [6:0]  font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          k = 0;
  logic [15:0] m_val = '0, p_val = '0;
  logic [3:0]  m_dots = '0, m_en = '0, p_dots = '0, p_en = '0;
  logic        p_v = 0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1, e_fd = 0;
  function automatic int dg(int n);
    return (n / SLOT) % D;
  endfunction
  function automatic bit lit_f(int d);
    return m_en[d] && !(lz_suppress && d != 0 && (m_val >> (4 * d)) == 16'h0);
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= 0; m_val <= '0; m_dots <= '0; m_en <= '0; p_v <= 0;
      e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1; e_fd <= 0;
    end else begin
      k <= k + 1;
      e_fd <= ((k + 1) % FRAME == 0);
      if ((k + 1) % FRAME == 0) begin
        if (value_load) begin m_val <= value; m_dots <= dots; m_en <= digit_en; end
        else if (p_v) begin m_val <= p_val; m_dots <= p_dots; m_en <= p_en; end
        p_v <= 0;
      end else if (value_load) begin
        p_val <= value; p_dots <= dots; p_en <= digit_en; p_v <= 1;
      end
      if ((k + 1) % SLOT == 0) begin
        e_an <= 4'hF; e_seg <= 7'h7F; e_dp <= 1;
      end else if ((k + 1) % SLOT == BC) begin
        e_an  <= lit_f(dg(k + 1)) ? ~(4'b1 << dg(k + 1)) : 4'hF;
        e_seg <= font[4'(m_val >> (4 * dg(k + 1)))];
        e_dp  <= lit_f(dg(k + 1)) ? ~m_dots[dg(k + 1)] : 1'b1;
      end
    end
  end
  task automatic load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    @(negedge clk);
    value = v; dots = d; digit_en = e; value_load = 1;
    @(negedge clk);
    value_load = 0;
  endtask
  task automatic to_boundary();
    while (k % FRAME != 0) @(negedge clk);
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        failures++; $display("FAIL reset got %h exp %h", {anodes, segments, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    rst = 0;
  endtask
  task automatic test_scan();
    int lit_cnt = 0;
    load(16'h1234, 4'h0, 4'hF);
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++; $display("FAIL scan k=%0d got %h exp %h", k, {anodes, segments, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
      end
      if (anodes == 4'b0111) begin
        lit_cnt++;
        checks++;
        if (segments !== 7'b1111001) begin failures++; $display("FAIL scan_digit3 got %b exp 1111001", segments); end
      end
    end
    checks++;
    if (lit_cnt !== CD) begin failures++; $display("FAIL scan_lit_cycles got %0d exp %0d", lit_cnt, CD); end
  endtask
  task automatic test_frame_done();
    int last = -1, pulses = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_done) begin
        if (last >= 0) begin
          checks++;
          if (k - last !== FRAME) begin failures++; $display("FAIL fd_period got %0d exp %0d", k - last, FRAME); end
        end
        last = k; pulses++;
      end
      checks++;
      if (frame_done !== e_fd) begin failures++; $display("FAIL fd k=%0d got %b exp %b", k, frame_done, e_fd); end
    end
    checks++;
    if (pulses !== 3) begin failures++; $display("FAIL fd_count got %0d exp 3", pulses); end
  endtask
  task automatic test_lz();
    lz_suppress = 1;
    for (int p = 0; p < 2; p++) begin
      load(p == 0 ? 16'h0005 : 16'h0000, 4'h0, 4'hF);
      to_boundary();
      for (int i = 0; i < FRAME; i++) begin
        @(negedge clk);
        checks++;
        if ({anodes, segments, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
          failures++; $display("FAIL lz k=%0d got %h exp %h", k, {anodes, segments, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
        end
        if (anodes != 4'hF) begin
          checks++;
          if ({anodes, segments} !== {4'b1110, p == 0 ? 7'b0010010 : 7'b1000000}) begin
            failures++; $display("FAIL lz_digit got %b/%b exp 1110/%b", anodes, segments, p == 0 ? 7'b0010010 : 7'b1000000);
          end
        end
      end
    end
    lz_suppress = 0;
  endtask
  task automatic test_mid_frame();
    load(16'h1234, 4'h0, 4'hF);
    to_boundary();
    while (k % FRAME != FRAME / 2) @(negedge clk);
    value = 16'hAAAA; value_load = 1;
    @(negedge clk);
    value_load = 0;
    while (k % FRAME != FRAME - 1) begin
      checks++;
      if ({anodes, segments, dp} !== {e_an, e_seg, e_dp}) begin
        failures++; $display("FAIL hold k=%0d got %h exp %h", k, {anodes, segments, dp}, {e_an, e_seg, e_dp});
      end
      if (anodes != 4'hF) begin
        checks++;
        if (segments == 7'h08) begin failures++; $display("FAIL hold_early got %b exp not 0001000", segments); end
      end
      @(negedge clk);
    end
    value = 16'hBBBB; value_load = 1;
    @(negedge clk);
    value_load = 0;
    for (int i = 0; i < FRAME - 1; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++; $display("FAIL bnd k=%0d got %h exp %h", k, {anodes, segments, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
      end
      if (anodes != 4'hF) begin
        checks++;
        if (segments !== 7'h03) begin failures++; $display("FAIL bnd_b got %b exp 0000011", segments); end
      end
    end
  endtask
  task automatic test_enables();
    int last = -1;
    load(16'h9876, 4'b0001, 4'b0101);
    to_boundary();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++; $display("FAIL en k=%0d got %h exp %h", k, {anodes, segments, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
      end
      checks++;
      if (anodes[1] !== 1'b1 || anodes[3] !== 1'b1 || (dp === 1'b0 && anodes !== 4'b1110)) begin
        failures++; $display("FAIL en_mask got an=%b dp=%b exp an[1],an[3]=1, dp low only with 1110", anodes, dp);
      end
      if (frame_done) begin
        if (last >= 0) begin
          checks++;
          if (k - last !== FRAME) begin failures++; $display("FAIL en_period got %0d exp %0d", k - last, FRAME); end
        end
        last = k;
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++; $display("FAIL rand k=%0d got %h exp %h", k, {anodes, segments, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
      end
      value_load = ($urandom_range(7) == 0);
      value = $urandom_range(3) == 0 ? 16'($urandom_range(255)) : 16'($urandom);
      dots = 4'($urandom); digit_en = 4'($urandom);
      if ($urandom_range(15) == 0) lz_suppress = ~lz_suppress;
    end
    value_load = 0;
  endtask
  task automatic test_async_reset();
    int n = 0;
    load(16'h4321, 4'hF, 4'hF);
    to_boundary();
    while (anodes == 4'hF && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (anodes == 4'hF) begin failures++; $display("FAIL arst_wait got timeout exp lit digit"); end
    #2 rst = 1;
    #1;
    checks++;
    if ({anodes, segments, dp, frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      failures++; $display("FAIL arst got %h exp %h", {anodes, segments, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < FRAME + SLOT; i++) begin
      @(negedge clk);
      checks++;
      if ({anodes, segments, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        failures++; $display("FAIL arst_post k=%0d got %h exp %h", k, {anodes, segments, dp, frame_done}, {e_an, e_seg, e_dp, e_fd});
      end
      checks++;
      if (anodes !== 4'hF || (k % SLOT >= BC && segments !== 7'h40)) begin
        failures++; $display("FAIL arst_zero got %b/%b exp 1111/zero glyph", anodes, segments);
      end
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_frame_done();
    test_lz();
    test_mid_frame();
    test_enables();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
